// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package div_pkg;

    // Divisor width; dividend and quotient are twice as wide.
    localparam int DIV_N     = 4;
    localparam int DIV_DVD_W = 2 * DIV_N;
    localparam int DIV_REM_W = DIV_N + 1;
    localparam int DIV_CNT_W = $clog2(2 * DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] divisor_ext;
    logic [N+1:0] diff;

    // Compare and conditionally subtract at N+2 bits so no carry is lost;
    // the result always fits back into N+1 bits because it is below divisor.
    always_comb begin
        shifted     = {rem_in, bit_in};
        divisor_ext = {2'b00, divisor};
        diff        = shifted - divisor_ext;
        if (shifted >= divisor_ext) begin
            rem_out = diff[N:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[N:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div8u4_seq.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per cycle (restoring, MSB first), valid/ready on both sides.
module div8u4_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int DW = 2 * N;
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * N - 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          dbz_q, dbz_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N:0]    step_rem;
    logic          step_bit;

    // The dividend register shifts left each step, so its MSB is always the
    // next bit to bring down.
    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DW-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Next-state and datapath decode for IDLE -> CALC/DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    cnt_d      = '0;
                    rem_d      = '0;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor short-circuits straight to a saturated result.
                        quo_d       = '1;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[DW-2:0], step_bit};
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                if (cnt_q == LAST_STEP) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result registers are untouched here, so they hold under backpressure.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q[N-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8u4_seq.sv
// Self-checking bench for div8u4_seq: directed vector table, reset abort,
// and an exhaustive nonzero-divisor sweep with random output stalls.
module tb_div8u4_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    div8u4_seq #(.N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         stall;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one operand pair across its accept edge and push the expectation.
    task automatic send(input logic [7:0] dvd, input logic [3:0] dvs, input exp_t e);
        int wait_cyc;
        wait_cyc = 0;
        @(negedge clk);
        while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result (jamming junk on the inputs meanwhile), compare
    // against the scoreboard head, then hold out_ready low for 'stall' cycles.
    task automatic receive(input int stall, input bit sweep, input string tag);
        int   lat;
        exp_t e;
        logic [7:0] q_hold;
        logic [3:0] r_hold;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            in_valid = 1'($urandom_range(0, 1));
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk({tag, "_out_valid_timeout"}, 0, 1);
            return;
        end
        if (sweep) begin
            chk({tag, "_result"}, {quotient, remainder, div_by_zero, lat[7:0]},
                {e.q, e.r, e.dbz, e.lat[7:0]});
        end else begin
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_quotient"}, quotient, e.q);
            chk({tag, "_remainder"}, remainder, e.r);
            chk({tag, "_div_by_zero"}, div_by_zero, e.dbz);
        end
        q_hold = quotient;
        r_hold = remainder;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall_hold"}, {out_valid, in_ready, quotient, remainder},
                {1'b1, 1'b0, q_hold, r_hold});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (!sweep) chk({tag, "_back_to_idle"}, {out_valid, in_ready}, 2'b01);
        $display("op %s: q=%0d r=%0d dbz=%0d lat=%0d", tag, quotient, remainder, div_by_zero, lat);
    endtask

    task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs, input int stall,
                          input bit sweep, input string tag);
        exp_t e;
        if (dvs == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = dvd / {4'd0, dvs};
            e.r = 4'(dvd % {4'd0, dvs});
            e.dbz = 1'b0;
            e.lat = 8;
        end
        send(dvd, dvs, e);
        receive(stall, sweep, tag);
    endtask

    vec_t vecs[9];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 5};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 0};
        vecs[2] = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0, 1};
        vecs[3] = '{8'h5A,  4'd0,  8'hFF,  4'd0, 1'b1, 2};
        vecs[4] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 0};
        vecs[5] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 0};
        vecs[6] = '{8'd7,   4'd8,  8'd0,   4'd7, 1'b0, 0};
        vecs[7] = '{8'd254, 4'd13, 8'd19,  4'd7, 1'b0, 3};
        vecs[8] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1, 0};

        #12;
        chk("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
            {1'b1, 1'b0, 8'd0, 4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed expectations.
        foreach (vecs[i]) begin
            exp_t e;
            e.q   = vecs[i].q;
            e.r   = vecs[i].r;
            e.dbz = vecs[i].dbz;
            e.lat = vecs[i].dbz ? 1 : 8;
            send(vecs[i].dvd, vecs[i].dvs, e);
            receive(vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset pulsed in the middle of CALC aborts without a result.
        begin
            exp_t e;
            e = '{8'd28, 4'd4, 1'b0, 8};
            send(8'd200, 4'd7, e);
            repeat (3) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_reset_values", {in_ready, out_valid, quotient, remainder, div_by_zero},
                {1'b1, 1'b0, 8'd0, 4'd0, 1'b0});
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (10) begin
                @(posedge clk);
                #1;
                chk("abort_no_result", out_valid, 0);
            end
            e = '{8'd11, 4'd1, 1'b0, 8};
            send(8'd100, 4'd9, e);
            receive(0, 1'b0, "after_abort");
        end

        // Exhaustive sweep of nonzero divisors with random stalls.
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                run_op(8'(n), 4'(d), int'($urandom_range(0, 2)), 1'b1,
                       $sformatf("%0d/%0d", n, d));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
